// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// byte-mask width, default base address and the address-to-word-index mapping.
package dmem_pkg;

  localparam int unsigned MASK_W = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word index relative to base; the mask makes out-of-range addresses wrap.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int unsigned depth);
    return ((addr - base) >> 2) & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage (master) and the
// responder (slave). rsp_err exists only when DMEM_ERR_EN is defined.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
`ifdef DMEM_ERR_EN
  logic              rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered
// read port that only updates when en is high.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: storage has no reset so it maps onto a RAM macro; contents survive rst.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (we && wmask[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the load/store port: one request at a time, serviced from
// dmem_array after LATENCY wait cycles. Optional error checking: DMEM_ERR_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic              commit;
  logic              addr_err;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_rdata;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wen_d   = bus.req_wen;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      // WAIT always lasts at least one cycle so the RAM sees a registered
      // address; the commit edge is the one that leaves WAIT with cnt at zero.
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

`ifdef DMEM_ERR_EN
  logic [31:0] offset;
  assign offset   = addr_q - BASE_ADDR;
  assign addr_err = ((offset >> 2) >= 32'(DEPTH_WORDS)) || (addr_q[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign ram_addr = AW'(word_index(addr_q, BASE_ADDR, DEPTH_WORDS));

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (wen_q && !addr_err),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .wmask (wmask_q),
    .rdata (ram_rdata)
  );

  // The RAM read register only moves at a commit, so gating it by state gives
  // load data held through RESP and zero everywhere else.
  assign bus.req_ready = rst && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP && !wen_q && !addr_err) ? ram_rdata : 32'h0;
`ifdef DMEM_ERR_EN
  assign bus.rsp_err   = (state_q == RESP) && addr_err;
`endif
  assign busy          = (state_q != IDLE);

endmodule
